// File: rtl/chunked_wide_adder_pkg.sv
// Shared definitions for the chunked wide adder.
//   state_t : FSM state encoding (idle / run / done)
//   clog2   : ceiling log2 usable in constant expressions
package chunked_wide_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= v (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/chunked_wide_adder_rca_nbit.sv
// rca_nbit: combinational n-bit ripple-carry adder built from per-bit full adders.
//   x, y  : n-bit addends
//   cin   : carry into bit 0
//   s     : n-bit sum
//   cout  : carry out of bit n-1
module rca_nbit #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_full_adder
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[n];

endmodule

// File: rtl/chunked_wide_adder.sv
// chunked_wide_adder: adds two N*K-bit operands by streaming N-bit chunks, LSB first,
// through a single rca_nbit, one chunk per clock, with the chunk carry registered.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand handshake for a, b, cin
//   a, b, cin           : operands and carry into chunk 0
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : (a+b+cin) mod 2^W, carry out of bit W-1, two's-complement overflow
module chunked_wide_adder
    import chunked_wide_adder_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           ovf
);

    localparam int unsigned W    = N * K;
    localparam int unsigned IdxW = (K > 1) ? clog2(K) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(K - 1);

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [IdxW-1:0] idx_q;

    logic [N-1:0]    rca_x;
    logic [N-1:0]    rca_y;
    logic [N-1:0]    rca_s;
    logic            rca_cout;

    // Chunk mux: select the current N-bit slice of each stored operand.
    always_comb begin
        rca_x = a_q[idx_q*N +: N];
        rca_y = b_q[idx_q*N +: N];
    end

    rca_nbit #(
        .n(N)
    ) u_rca (
        .x   (rca_x),
        .y   (rca_y),
        .cin (carry_q),
        .s   (rca_s),
        .cout(rca_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        idx_q    <= '0;
                        // Clear so upper chunks never show a previous result.
                        sum      <= '0;
                        cout     <= 1'b0;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[idx_q*N +: N] <= rca_s;
                    carry_q           <= rca_cout;
                    if (idx_q == IdxLast) begin
                        idx_q     <= '0;
                        cout      <= rca_cout;
                        // Same-sign operands whose sum flips sign overflowed.
                        ovf       <= (a_q[W-1] == b_q[W-1]) && (rca_s[N-1] != a_q[W-1]);
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Self-checking bench for chunked_wide_adder (N=4, K=4): directed cases for carry
// propagation, overflow, back-pressure and mid-operation reset, then randomized
// handshakes checked against an arithmetic reference model.
module tb_chunked_wide_adder;

    localparam int unsigned N = 4;
    localparam int unsigned K = 4;
    localparam int unsigned W = N * K;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    chunked_wide_adder #(
        .N(N),
        .K(K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision addition and signed-range overflow.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        int s;
        s = int'(signed'(x)) + int'(signed'(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // Present operands at a falling edge, hold until accepted, then scramble them.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
    endtask

    // Count edges from acceptance until out_valid appears.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        int lat;
        send(x, y, c);
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'(K));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        release_result();
    endtask

    initial begin
        logic [W:0]   exp_full;
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         held_ovf;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        directed("t1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("t3a", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        directed("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-pressure: result must stay put while out_ready is low.
        send(16'hA5A5, 16'h1357, 1'b1);
        wait_result(lat);
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = ovf;
        exp_full  = ref_sum(16'hA5A5, 16'h1357, 1'b1);
        check("bp_sum", 32'(held_sum), 32'(exp_full[W-1:0]));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_sum_stable", 32'(sum), 32'(exp_full[W-1:0]));
            check("bp_cout_stable", 32'(cout), 32'(exp_full[W]));
            check("bp_ovf_stable", 32'(ovf), 32'(ref_ovf(16'hA5A5, 16'h1357, 1'b1)));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        release_result();

        // Reset two chunks into a run.
        send(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        directed("t5", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Randomized handshakes with a scoreboard queue.
        begin
            logic [W:0] exp_q[$];
            logic       ovf_q[$];
            int         accepted;
            int         cycles;
            accepted = 0;
            cycles   = 0;
            while ((accepted < 1000 || exp_q.size() != 0) && cycles < 60000) begin
                @(negedge clk);
                cycles++;
                in_valid  = (accepted < 1000) ? 1'($urandom) : 1'b0;
                a         = W'($urandom);
                b         = W'($urandom);
                cin       = 1'($urandom);
                out_ready = 1'($urandom);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_spurious_result", 32'd1, 32'd0);
                    end else begin
                        exp_full = exp_q.pop_front();
                        check("rnd_sum", 32'(sum), 32'(exp_full[W-1:0]));
                        check("rnd_cout", 32'(cout), 32'(exp_full[W]));
                        check("rnd_ovf", 32'(ovf), 32'(ovf_q.pop_front()));
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_sum(a, b, cin));
                    ovf_q.push_back(ref_ovf(a, b, cin));
                    accepted++;
                end
            end
            check("rnd_all_accepted", 32'(accepted), 32'd1000);
            check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
